// File: rtl/addsub_scheduler.sv
// rtl/addsub_scheduler.sv - two-requester scheduler for a shared 32-bit add/sub/SLT datapath
//
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   req_valid[1:0]/req_ready[1:0] request handshake, one bit per requester
//   req_op0/1, req_a0/1, req_b0/1 per-requester op code (00 ADD, 01 SUB, 10 SLT, 11 ADD) and operands
//   rsp_valid[1:0]/rsp_ready[1:0] response handshake, only the owner's bit is used
//   rsp_result/carryout/overflow captured datapath outputs
//   busy                          high whenever not idle
//   dp_a, dp_b, dp_carryin, dp_slt registered datapath controls
//   dp_sum, dp_carryout, dp_overflow datapath results
// Build option: ADDSUB_SCHED_RR_EN selects round-robin tie breaking (default: requester 0 wins).
module addsub_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_op0,
  input  logic [1:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carryout,
  output logic        rsp_overflow,
  output logic        busy,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_carryin,
  output logic        dp_slt,
  input  logic [31:0] dp_sum,
  input  logic        dp_carryout,
  input  logic        dp_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic [31:0] dp_a_q, dp_a_d;
  logic [31:0] dp_b_q, dp_b_d;
  logic        dp_carryin_q, dp_carryin_d;
  logic        dp_slt_q, dp_slt_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_carryout_q, rsp_carryout_d;
  logic        rsp_overflow_q, rsp_overflow_d;

  logic        tie_winner;
  logic        grant;
  logic        accept;
  logic [1:0]  sel_op;

`ifdef ADDSUB_SCHED_RR_EN
  logic        rr_ptr_q, rr_ptr_d;
  assign tie_winner = rr_ptr_q;
`else
  assign tie_winner = 1'b0;
`endif

  // Grant index: a lone valid requester wins outright; a tie uses tie_winner.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
      grant = tie_winner;
    end else begin
      grant = ~req_valid[0];
    end
  end

  // Ready is suppressed during reset so no requester believes an op was taken
  // in a cycle whose effects reset discards.
  assign accept = (state_q == S_IDLE) && (|req_valid) && !reset;
  assign sel_op = grant ? req_op1 : req_op0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      owner_q        <= 1'b0;
      dp_a_q         <= 32'd0;
      dp_b_q         <= 32'd0;
      dp_carryin_q   <= 1'b0;
      dp_slt_q       <= 1'b0;
      rsp_result_q   <= 32'd0;
      rsp_carryout_q <= 1'b0;
      rsp_overflow_q <= 1'b0;
`ifdef ADDSUB_SCHED_RR_EN
      rr_ptr_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      owner_q        <= owner_d;
      dp_a_q         <= dp_a_d;
      dp_b_q         <= dp_b_d;
      dp_carryin_q   <= dp_carryin_d;
      dp_slt_q       <= dp_slt_d;
      rsp_result_q   <= rsp_result_d;
      rsp_carryout_q <= rsp_carryout_d;
      rsp_overflow_q <= rsp_overflow_d;
`ifdef ADDSUB_SCHED_RR_EN
      rr_ptr_q       <= rr_ptr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    owner_d        = owner_q;
    dp_a_d         = dp_a_q;
    dp_b_d         = dp_b_q;
    dp_carryin_d   = dp_carryin_q;
    dp_slt_d       = dp_slt_q;
    rsp_result_d   = rsp_result_q;
    rsp_carryout_d = rsp_carryout_q;
    rsp_overflow_d = rsp_overflow_q;
`ifdef ADDSUB_SCHED_RR_EN
    rr_ptr_d       = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d      = S_SETTLE;
          owner_d      = grant;
          dp_a_d       = grant ? req_a1 : req_a0;
          dp_b_d       = grant ? req_b1 : req_b0;
          // SUB and SLT both subtract: carry-in 1 also selects inverted b.
          dp_carryin_d = (sel_op == 2'b01) || (sel_op == 2'b10);
          dp_slt_d     = (sel_op == 2'b10);
          cnt_d        = 8'(SETTLE_CYCLES - 1);
`ifdef ADDSUB_SCHED_RR_EN
          rr_ptr_d     = ~grant;
`endif
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d        = S_DONE;
          rsp_result_d   = dp_sum;
          rsp_carryout_d = dp_carryout;
          rsp_overflow_d = dp_overflow;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        if (rsp_ready[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (accept) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
    if (state_q == S_DONE) begin
      rsp_valid = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign dp_a         = dp_a_q;
  assign dp_b         = dp_b_q;
  assign dp_carryin   = dp_carryin_q;
  assign dp_slt       = dp_slt_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carryout = rsp_carryout_q;
  assign rsp_overflow = rsp_overflow_q;

endmodule

// File: tb/tb_addsub_scheduler.sv
// tb/tb_addsub_scheduler.sv - self-checking bench for addsub_scheduler
module tb_addsub_scheduler;

  localparam int SETTLE = 4;
  localparam int DLY    = SETTLE - 1;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [1:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carryout, rsp_overflow, busy;
  logic [31:0] dp_a, dp_b, dp_sum;
  logic        dp_carryin, dp_slt, dp_carryout, dp_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  addsub_scheduler #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow),
    .busy(busy),
    .dp_a(dp_a), .dp_b(dp_b), .dp_carryin(dp_carryin), .dp_slt(dp_slt),
    .dp_sum(dp_sum), .dp_carryout(dp_carryout), .dp_overflow(dp_overflow)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: bit-level adder whose outputs only reach the pins
  // SETTLE-1 edges after the inputs change, so an early capture sees stale data.
  logic [33:0] dp_comb;
  logic [33:0] pipe [DLY];
  always_comb begin
    logic [31:0] bx;
    logic [32:0] s;
    logic        ov;
    bx = dp_carryin ? ~dp_b : dp_b;
    s  = {1'b0, dp_a} + {1'b0, bx} + {32'd0, dp_carryin};
    ov = (dp_a[31] == bx[31]) && (s[31] != dp_a[31]);
    if (dp_slt) dp_comb = {1'b0, ov, 31'd0, s[31] ^ ov};
    else        dp_comb = {s[32], ov, s[31:0]};
  end
  always @(posedge clk) begin
    pipe[0] <= dp_comb;
    for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_carryout = pipe[DLY-1][33];
  assign dp_overflow = pipe[DLY-1][32];
  assign dp_sum      = pipe[DLY-1][31:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed/unsigned arithmetic on wide integers.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic co, output logic ovf);
    longint sa, sb, ua, ub, d, s;
    logic   dov;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    d   = sa - sb;
    s   = sa + sb;
    dov = (d > SMAX) || (d < SMIN);
    case (op)
      2'b01: begin r = 32'(d); co = (ua >= ub); ovf = dov; end
      2'b10: begin r = (sa < sb) ? 32'd1 : 32'd0; co = 1'b0; ovf = dov; end
      default: begin r = 32'(s); co = (ua + ub) > 64'sh0FFFFFFFF; ovf = (s > SMAX) || (s < SMIN); end
    endcase
  endfunction

  task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
  endtask

  // One full transaction on requester r with exact latency checks.
  task automatic do_op(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eco, input logic eovf, input int stall);
    int n;
    int bad;
    logic [1:0] own;
    own = (r == 0) ? 2'b01 : 2'b10;
    set_req(r, op, a, b);
    req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (req_ready[r] !== 1'b1 && n < 50) begin step(); n++; end
    check("accept_timeout", 32'(n < 50), 32'd1);
    step();
    req_valid[r] = 1'b0;
    check("dp_a", dp_a, a);
    check("dp_b", dp_b, b);
    check("dp_carryin", 32'(dp_carryin), 32'((op == 2'b01) || (op == 2'b10)));
    check("dp_slt", 32'(dp_slt), 32'(op == 2'b10));
    bad = 0;
    for (int k = 1; k <= SETTLE; k++) begin
      if (rsp_valid !== 2'b00 || busy !== 1'b1) bad++;
      if (k < SETTLE) step();
    end
    check("early_rsp", 32'(bad), 32'd0);
    step();
    check("rsp_valid", 32'(rsp_valid), 32'(own));
    check("rsp_result", rsp_result, er);
    check("rsp_carryout", 32'(rsp_carryout), 32'(eco));
    check("rsp_overflow", 32'(rsp_overflow), 32'(eovf));
    bad = 0;
    rsp_ready = ~own;
    for (int s = 0; s < stall; s++) begin
      step();
      if (rsp_valid !== own || rsp_result !== er) bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    rsp_ready = own;
    step();
    rsp_ready = 2'b00;
    check("idle_after_rsp", 32'({busy, rsp_valid}), 32'd0);
  endtask

  typedef struct {
    int          req;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    int bad;
    int ptr;
    int exp_w;
    logic [31:0] er;
    logic eco, eovf;
    logic [1:0] op;
    logic [31:0] a, b;
    int r;

    vecs[0] = '{0, 2'b00, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vecs[1] = '{1, 2'b01, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2] = '{1, 2'b10, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
    vecs[3] = '{0, 2'b00, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{1, 2'b01, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{0, 2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
    vecs[6] = '{0, 2'b10, 32'd5,        32'd3,        32'd0,        1'b0, 1'b0};
    vecs[7] = '{1, 2'b10, 32'h80000000, 32'd1,        32'd1,        1'b0, 1'b1};

    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    set_req(0, 2'b00, 32'd0, 32'd0);
    set_req(1, 2'b00, 32'd0, 32'd0);
    step(); step(); step();
    reset = 1'b0;
    #1;
    check("reset_state", 32'({req_ready, rsp_valid, busy, dp_carryin, dp_slt, rsp_carryout, rsp_overflow}), 32'd0);
    check("reset_dp", dp_a | dp_b | rsp_result, 32'd0);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].co, vecs[i].ovf, i % 3);

    // Reset in the middle of SETTLE with both requesters valid.
    set_req(0, 2'b00, 32'd9, 32'd9);
    req_valid = 2'b01;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 50) begin step(); n++; end
    step(); step();
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1; req_valid = 2'b11;
    step(); step();
    reset = 1'b0; req_valid = 2'b00;
    #1;
    check("midreset_state", 32'({req_ready, rsp_valid, busy, dp_carryin, dp_slt, rsp_carryout, rsp_overflow}), 32'd0);
    check("midreset_dp", dp_a | dp_b | rsp_result, 32'd0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rsp_valid !== 2'b00 || busy !== 1'b0) bad++;
    end
    check("no_rsp_after_reset", 32'(bad), 32'd0);

    // Ties with both requesters held valid, pointer fresh from reset.
    ptr = 0;
    set_req(0, 2'b00, 32'd10, 32'd1);
    set_req(1, 2'b00, 32'd20, 32'd2);
    req_valid = 2'b11;
    #1;
    for (int t = 0; t < 3; t++) begin
`ifdef ADDSUB_SCHED_RR_EN
      exp_w = ptr;
`else
      exp_w = 0;
`endif
      n = 0;
      while (req_ready === 2'b00 && n < 50) begin step(); n++; end
      check("tie_grant", 32'(req_ready), (exp_w == 0) ? 32'd1 : 32'd2);
      step();
      ptr = 1 - exp_w;
      n = 0;
      while (rsp_valid === 2'b00 && n < 50) begin step(); n++; end
      check("tie_rsp_valid", 32'(rsp_valid), (exp_w == 0) ? 32'd1 : 32'd2);
      check("tie_result", rsp_result, (exp_w == 0) ? 32'd11 : 32'd22);
      rsp_ready = 2'b11;
      step();
      rsp_ready = 2'b00;
      if (t == 2) req_valid = 2'b00;
      check("tie_idle", 32'(busy), 32'd0);
    end
    step();

    // Backpressure: response held for 10 cycles while requester 1 waits.
    set_req(0, 2'b00, 32'd100, 32'd23);
    req_valid = 2'b01;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 50) begin step(); n++; end
    step();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid === 2'b00 && n < 50) begin step(); n++; end
    set_req(1, 2'b01, 32'd50, 32'd8);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result", rsp_result, 32'd123);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      step();
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_accept", 32'(req_ready), 32'd2);
    step();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid === 2'b00 && n < 50) begin step(); n++; end
    check("bp_second_valid", 32'(rsp_valid), 32'd2);
    check("bp_second_result", rsp_result, 32'd42);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;

    // Random operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      r  = int'($urandom_range(1, 0));
      op = 2'($urandom_range(3, 0));
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      ref_model(op, a, b, er, eco, eovf);
      do_op(r, op, a, b, er, eco, eovf, int'($urandom_range(3, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_scheduler.md
# addsub_scheduler

Two-requester scheduler that shares one 32-bit gate-level adder/subtractor/SLT datapath between two clients. Accepts one operation at a time over a valid/ready handshake and drives the datapath's operand and mode inputs from registers. Waits a fixed number of cycles for the ripple-carry result to settle, then captures it and returns it to the owning requester over a second valid/ready handshake. Sits between the ALU datapath and its clients, such as the execute-stage sequencer and the keyboard-input handler.

## Interface
- SETTLE_CYCLES, 4, cycles the datapath is given to settle after operands change; legal range 1..255.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: requester i's operation is accepted this cycle.
- req_op0, req_op1  in  2 each  operation code: 00 ADD, 01 SUB, 10 SLT, 11 treated as ADD.
- req_a0, req_a1, req_b0, req_b1  in  32 each  operands, signed two's complement.
- rsp_valid  out  2  bit i: result for requester i is available.
- rsp_ready  in  2  bit i: requester i takes the result.
- rsp_result  out  32  captured datapath sum.
- rsp_carryout  out  1  captured datapath carryout.
- rsp_overflow  out  1  captured datapath overflow.
- busy  out  1  high in every state except IDLE.
- dp_a, dp_b  out  32 each  registered operands to the datapath.
- dp_carryin  out  1  1 for SUB/SLT, else 0; this is also the datapath's invert-b select.
- dp_slt  out  1  1 for SLT only.
- dp_sum  in  32  datapath result.
- dp_carryout, dp_overflow  in  1 each  datapath flags.

## Operation
- States: IDLE, SETTLE, DONE.
- **IDLE**
  - The grant goes to the single valid requester. If both are valid, it goes per the arbitration rule (see Configuration).
  - req_ready[g] = 1 for the granted requester g only, combinationally from req_valid. Requesters must not make valid depend on ready.
  - On handshake: latch owner=g; load dp_a/dp_b/dp_carryin/dp_slt from requester g's fields; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
- **SETTLE**
  - req_ready = 0.
  - The counter decrements each cycle. When it is 0, capture dp_sum/dp_carryout/dp_overflow into the rsp_* registers and go to DONE.
- **DONE**
  - rsp_valid[owner] = 1; all rsp_* fields are held stable. dp_* are also held.
  - On rsp_ready[owner], go to IDLE next cycle.
  - rsp_ready of the non-owner is ignored.
- The block performs no arithmetic. Results and flags come from the datapath bit-exact; SLT carryout is the datapath's forced 0.
- Reset values: state IDLE; req_ready 0 unless granted in IDLE; rsp_valid 0; rsp_result 0; rsp_carryout 0; rsp_overflow 0; dp_a 0; dp_b 0; dp_carryin 0; dp_slt 0; busy 0; owner 0; RR pointer 0.
- Reset asserted in any state has priority over all other events. It discards the in-flight operation, and no response is ever issued for it.

## Timing
- A handshake in cycle T puts the new dp_* values out in cycle T+1.
- The capture edge ends cycle T+SETTLE_CYCLES, so rsp_valid is first high in cycle T+SETTLE_CYCLES+1.
- If the response handshake is in cycle D, the block is in IDLE in D+1, and the earliest next accept is D+1.
- Peak throughput is one operation per SETTLE_CYCLES+2 cycles.
- Requests arriving while busy wait with valid held; they are not queued.
- The response may stall indefinitely; nothing is lost while it stalls.

## Configuration
- Macro: ADDSUB_SCHED_RR_EN.
- **Defined:** round-robin arbitration.
  - The pointer names the preferred requester on a tie.
  - After each accept, the pointer is set to the other requester (1-g).
- **Undefined:** fixed priority; requester 0 always wins a tie. The pointer logic is absent.

## Test plan
- **Reset:** SETTLE_CYCLES=4. Assert reset 2 cycles with req_valid=2'b11 and the FSM mid-SETTLE → every output is at its reset value the cycle after reset, and no rsp_valid pulse appears.
- **ADD:** requester 0 ADD, a=5, b=7, handshake in T → dp_carryin=0 and dp_slt=0 from T+1; rsp_valid=2'b01 at T+5; result=12, carryout=0, overflow=0.
- **SUB and SLT:** requester 1 SUB, a=3, b=5 → result 0xFFFFFFFE, rsp_valid=2'b10. Then requester 1 SLT, a=0xFFFFFFFF, b=1 → dp_slt=1, result 0x00000001, carryout=0.
- **Tie, macro defined:** both valid with ADD in the same cycle, held valid → requester 0 is served first, then requester 1. A third back-to-back tie goes to requester 0.
- **Tie, macro undefined:** the same stimulus as above → requester 0 is served repeatedly while it stays valid.
- **Backpressure:** rsp_ready held 0 for 10 cycles in DONE → rsp_* stable, req_ready=0, busy=1 throughout. Then rsp_ready[owner]=1 → IDLE next cycle, and a pending request is accepted that cycle.
